deserializer_unit_cell: RTL and testbench

Receive-side counterpart of the serializer unit cell. Samples a one-bit-per-clock serial stream and reassembles a frame of eight 32-bit words, LSB first, into eight parallel output registers. Each completed word is announced with a one-cycle strobe, and the end of the frame is flagged separately. The block sits at the far end of the serial link and feeds downstream logic that consumes PAR_OUT1..PAR_OUT8.

---
 rtl/deserializer_unit_cell.sv | 86 ++++++++
 tb/tb_deserializer_unit_cell.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/deserializer_unit_cell.sv
// deserializer_unit_cell: rebuilds frames of eight 32-bit words from an LSB-first serial stream.
// Optional feature macro DESER_TIMEOUT_EN: abort a partial frame after TIMEOUT_CYCLES idle cycles and pulse FRAME_ERR.
module deserializer_unit_cell #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SERIAL_IN,
  input  logic        SERIAL_VALID,
  output logic [31:0] PAR_OUT1,
  output logic [31:0] PAR_OUT2,
  output logic [31:0] PAR_OUT3,
  output logic [31:0] PAR_OUT4,
  output logic [31:0] PAR_OUT5,
  output logic [31:0] PAR_OUT6,
  output logic [31:0] PAR_OUT7,
  output logic [31:0] PAR_OUT8,
  output logic        WORD_VALID,
  output logic [2:0]  WORD_INDEX,
  output logic        FRAME_DONE,
`ifdef DESER_TIMEOUT_EN
  output logic        FRAME_ERR,
`endif
  output logic        BUSY
);
  logic [4:0]  r_bit_cnt;
  logic [2:0]  r_word_cnt;
  logic [30:0] r_shift;
  logic [31:0] r_par [8];
  logic        w_commit;
  logic        w_abort;
  logic [4:0]  w_bit_nxt;
  logic [2:0]  w_word_nxt;
  assign w_commit = SERIAL_VALID && (r_bit_cnt == 5'd31);
`ifdef DESER_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  logic [GW-1:0] r_gap;
  // a valid bit on the would-be abort edge wins, so abort requires an idle edge
  assign w_abort = !SERIAL_VALID && BUSY && (r_gap == GW'(TIMEOUT_CYCLES - 1));
  // count consecutive idle edges while a frame is partially received
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) r_gap <= '0;
    else r_gap <= (SERIAL_VALID || !BUSY || w_abort) ? '0 : r_gap + 1'b1;
  // one-cycle error pulse on the aborting edge
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) FRAME_ERR <= 1'b0;
    else FRAME_ERR <= w_abort;
`else
  assign w_abort = 1'b0;
`endif
  // next counter values; the 5-bit bit counter wraps 31->0 naturally on a commit
  always_comb begin
    w_bit_nxt  = w_abort ? 5'd0 : SERIAL_VALID ? r_bit_cnt + 5'd1 : r_bit_cnt;
    w_word_nxt = w_abort ? 3'd0 : w_commit ? r_word_cnt + 3'd1 : r_word_cnt;
  end
  // frame position, shift register, word commits and status strobes
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_shift    <= '0;
      r_par      <= '{default: '0};
      WORD_VALID <= 1'b0;
      WORD_INDEX <= '0;
      FRAME_DONE <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      r_bit_cnt  <= w_bit_nxt;
      r_word_cnt <= w_word_nxt;
      BUSY       <= |{w_bit_nxt, w_word_nxt};
      WORD_VALID <= w_commit;
      FRAME_DONE <= w_commit && (r_word_cnt == 3'd7);
      if (w_commit) WORD_INDEX <= r_word_cnt;
      if (w_commit) r_par[r_word_cnt] <= {SERIAL_IN, r_shift};
      if (w_abort) r_shift <= '0;
      else if (SERIAL_VALID && !w_commit) r_shift[r_bit_cnt] <= SERIAL_IN;
    end
  assign PAR_OUT1 = r_par[0];
  assign PAR_OUT2 = r_par[1];
  assign PAR_OUT3 = r_par[2];
  assign PAR_OUT4 = r_par[3];
  assign PAR_OUT5 = r_par[4];
  assign PAR_OUT6 = r_par[5];
  assign PAR_OUT7 = r_par[6];
  assign PAR_OUT8 = r_par[7];
endmodule

// File: tb/tb_deserializer_unit_cell.sv
// tb_deserializer_unit_cell: directed scoreboard bench for deserializer_unit_cell.
module tb_deserializer_unit_cell;
  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] data;
    logic        done;
  } exp_t;
  logic        CLK;
  logic        RESET;
  logic        SERIAL_IN;
  logic        SERIAL_VALID;
  logic [31:0] PAR_OUT1, PAR_OUT2, PAR_OUT3, PAR_OUT4;
  logic [31:0] PAR_OUT5, PAR_OUT6, PAR_OUT7, PAR_OUT8;
  logic        WORD_VALID;
  logic [2:0]  WORD_INDEX;
  logic        FRAME_DONE;
  logic        BUSY;
`ifdef DESER_TIMEOUT_EN
  logic        FRAME_ERR;
  logic        exp_err;
`endif
  logic [31:0] par [8];
  logic [31:0] par_m [8];
  logic [31:0] fa [8];
  exp_t        q [$];
  logic [2:0]  wi;
  int          total;
  int          bad;
  int          cyc;
  int          wv;
  int          wv_prev;
  int          fd;
  int          fd_prev;
  deserializer_unit_cell #(.TIMEOUT_CYCLES(64)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .SERIAL_IN(SERIAL_IN),
    .SERIAL_VALID(SERIAL_VALID),
    .PAR_OUT1(PAR_OUT1),
    .PAR_OUT2(PAR_OUT2),
    .PAR_OUT3(PAR_OUT3),
    .PAR_OUT4(PAR_OUT4),
    .PAR_OUT5(PAR_OUT5),
    .PAR_OUT6(PAR_OUT6),
    .PAR_OUT7(PAR_OUT7),
    .PAR_OUT8(PAR_OUT8),
    .WORD_VALID(WORD_VALID),
    .WORD_INDEX(WORD_INDEX),
    .FRAME_DONE(FRAME_DONE),
`ifdef DESER_TIMEOUT_EN
    .FRAME_ERR(FRAME_ERR),
`endif
    .BUSY(BUSY)
  );
  assign par[0] = PAR_OUT1;
  assign par[1] = PAR_OUT2;
  assign par[2] = PAR_OUT3;
  assign par[3] = PAR_OUT4;
  assign par[4] = PAR_OUT5;
  assign par[5] = PAR_OUT6;
  assign par[6] = PAR_OUT7;
  assign par[7] = PAR_OUT8;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic v, input logic b);
    exp_t e;
    SERIAL_VALID = v;
    SERIAL_IN = b;
    @(posedge CLK);
    #1;
    cyc++;
    if (WORD_VALID) begin wv_prev = wv; wv = cyc; end
    if (FRAME_DONE) begin fd_prev = fd; fd = cyc; end
    chk("word_valid", {31'b0, WORD_VALID}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("word_index", {29'b0, WORD_INDEX}, {29'b0, e.idx});
      chk("par_out_commit", par[e.idx], e.data);
      chk("frame_done", {31'b0, FRAME_DONE}, {31'b0, e.done});
    end else
      chk("frame_done_idle", {31'b0, FRAME_DONE}, 32'd0);
`ifdef DESER_TIMEOUT_EN
    chk("frame_err", {31'b0, FRAME_ERR}, {31'b0, exp_err});
    exp_err = 1'b0;
`endif
  endtask
  task automatic send_bits(input logic [31:0] d, input int lo, input int hi, input bit pause);
    exp_t e;
    for (int i = lo; i <= hi; i++) begin
      if (i == 31) begin
        e.idx = wi;
        e.data = d;
        e.done = (wi == 3'd7);
        q.push_back(e);
        par_m[wi] = d;
        wi = wi + 3'd1;
      end
      tick(1'b1, d[i]);
      if (pause) tick(1'b0, 1'b0);
    end
  endtask
  task automatic send_frame(input bit ones, input bit pause);
    for (int k = 0; k < 8; k++) send_bits(ones ? 32'hFFFF_FFFF : fa[k], 0, 31, pause);
  endtask
  task automatic check_all(input string tag);
    for (int k = 0; k < 8; k++) chk(tag, par[k], par_m[k]);
  endtask
  task automatic do_reset();
    SERIAL_VALID = 1'b0;
    SERIAL_IN = 1'b0;
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 8; k++) chk("rst_par_out", par[k], 32'd0);
    chk("rst_word_valid", {31'b0, WORD_VALID}, 32'd0);
    chk("rst_word_index", {29'b0, WORD_INDEX}, 32'd0);
    chk("rst_frame_done", {31'b0, FRAME_DONE}, 32'd0);
    chk("rst_busy", {31'b0, BUSY}, 32'd0);
`ifdef DESER_TIMEOUT_EN
    chk("rst_frame_err", {31'b0, FRAME_ERR}, 32'd0);
`endif
    RESET = 1'b1;
    q.delete();
    wi = 3'd0;
    for (int k = 0; k < 8; k++) par_m[k] = 32'd0;
  endtask
  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    wv = 0;
    wv_prev = 0;
    fd = 0;
    fd_prev = 0;
`ifdef DESER_TIMEOUT_EN
    exp_err = 1'b0;
`endif
    fa[0] = 32'hA5A5_0001;
    fa[1] = 32'h0000_0002;
    fa[2] = 32'h1234_5603;
    fa[3] = 32'hDEAD_BE04;
    fa[4] = 32'h0F0F_0F05;
    fa[5] = 32'hF0F0_F006;
    fa[6] = 32'h7FFF_FF07;
    fa[7] = 32'h8000_0008;
    do_reset();
    send_frame(1'b0, 1'b0);
    chk("t1_busy_end", {31'b0, BUSY}, 32'd0);
    chk("t1_wv_spacing", 32'(wv - wv_prev), 32'd32);
    check_all("t1_par_out");
    send_frame(1'b0, 1'b1);
    chk("t2_busy_end", {31'b0, BUSY}, 32'd0);
    chk("t2_wv_spacing", 32'(wv - wv_prev), 32'd64);
    check_all("t2_par_out");
    send_frame(1'b0, 1'b0);
    send_frame(1'b1, 1'b0);
    chk("t3_fd_spacing", 32'(fd - fd_prev), 32'd256);
    check_all("t3_par_out");
    send_bits(fa[0], 0, 31, 1'b0);
    send_bits(fa[1], 0, 7, 1'b0);
    chk("t4_busy_mid", {31'b0, BUSY}, 32'd1);
    do_reset();
    send_frame(1'b0, 1'b0);
    chk("t4_busy_end", {31'b0, BUSY}, 32'd0);
    check_all("t4_par_out");
`ifdef DESER_TIMEOUT_EN
    send_bits(32'h3C3C_3C3C, 0, 9, 1'b0);
    repeat (63) tick(1'b0, 1'b0);
    chk("t5_busy_63", {31'b0, BUSY}, 32'd1);
    send_bits(32'h3C3C_3C3C, 10, 31, 1'b0);
    for (int k = 1; k < 8; k++) send_bits(fa[k], 0, 31, 1'b0);
    check_all("t5_par_out_63");
    send_bits(fa[0], 0, 9, 1'b0);
    repeat (63) tick(1'b0, 1'b0);
    exp_err = 1'b1;
    tick(1'b0, 1'b0);
    chk("t5_busy_abort", {31'b0, BUSY}, 32'd0);
    wi = 3'd0;
    send_frame(1'b1, 1'b0);
    check_all("t5_par_out_after");
    do_reset();
    for (int k = 0; k < 3; k++) send_bits(fa[k], 0, 31, 1'b0);
    send_bits(fa[3], 0, 4, 1'b0);
    repeat (63) tick(1'b0, 1'b0);
    exp_err = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("t6_busy_abort", {31'b0, BUSY}, 32'd0);
    check_all("t6_par_out");
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
